// File: rtl/add_subb_csd_pipe.sv
// add_subb_csd_pipe: carry-free signed-digit add/subtract of two CSD operands,
// followed by an elastic valid/ready pipeline of STAGES register stages.
// Digit encoding: bit 2i = +1 flag, bit 2i+1 = -1 flag, 11 treated as 0 (flags err).
module add_subb_csd_pipe #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           subb_a,
  input  logic           subb_b,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     c,
  output logic [2*W-1:0] s,
  output logic           err
);

  // packed payload per stage: {err, carry digit, sum digits}
  localparam int DW = 2*W + 3;

  function automatic logic signed [2:0] dig_val(input logic [1:0] d);
    dig_val = d[0] ? 3'sd1 : (d[1] ? -3'sd1 : 3'sd0);
  endfunction

  function automatic logic [1:0] dig_enc(input logic signed [2:0] v);
    if (v == 3'sd1)       dig_enc = 2'b01;
    else if (v == -3'sd1) dig_enc = 2'b10;
    else                  dig_enc = 2'b00;
  endfunction

  logic [DW-1:0]     res_d;
  logic [1:0]        da, db;
  logic signed [2:0] p_v, w_v, t_lo, t_hi;
  logic              nn_lo, err_c;
  logic [2*W-1:0]    s_c;

  // Signed-digit sum: position sum p in [-2,2] splits into transfer t and interim w.
  // For |p|=1 the split is chosen from the lower position: if neither lower digit is
  // negative, the incoming transfer is in {0,+1}, so w is steered to -1; otherwise the
  // incoming transfer is in {-1,0} and w is steered to +1. w+t_in never leaves [-1,1].
  always_comb begin
    err_c = 1'b0;
    s_c   = '0;
    nn_lo = 1'b1;
    t_lo  = 3'sd0;
    t_hi  = 3'sd0;
    w_v   = 3'sd0;
    p_v   = 3'sd0;
    da    = 2'b00;
    db    = 2'b00;
    for (int i = 0; i < W; i++) begin
      da = a[2*i +: 2];
      db = b[2*i +: 2];
      if (da == 2'b11) begin
        err_c = 1'b1;
        da    = 2'b00;
      end
      if (db == 2'b11) begin
        err_c = 1'b1;
        db    = 2'b00;
      end
      if (subb_a) da = {da[0], da[1]};
      if (subb_b) db = {db[0], db[1]};
      p_v = dig_val(da) + dig_val(db);
      case (p_v)
        3'sd2: begin
          t_hi = 3'sd1;
          w_v  = 3'sd0;
        end
        -3'sd2: begin
          t_hi = -3'sd1;
          w_v  = 3'sd0;
        end
        3'sd1: begin
          t_hi = nn_lo ? 3'sd1 : 3'sd0;
          w_v  = nn_lo ? -3'sd1 : 3'sd1;
        end
        -3'sd1: begin
          t_hi = nn_lo ? 3'sd0 : -3'sd1;
          w_v  = nn_lo ? -3'sd1 : 3'sd1;
        end
        default: begin
          t_hi = 3'sd0;
          w_v  = 3'sd0;
        end
      endcase
      s_c[2*i +: 2] = dig_enc(w_v + t_lo);
      t_lo  = t_hi;
      nn_lo = ~da[1] & ~db[1];
    end
    res_d = {err_c, dig_enc(t_lo), s_c};
  end

  logic [STAGES-1:0] vld_q, vld_d, rdy, up_v;
  logic [DW-1:0]     dat_q [STAGES];
  logic [DW-1:0]     dat_d [STAGES];
  logic [DW-1:0]     up_dat [STAGES];
  logic              rdy_acc;

  // A stage may load when ena and either it or some stage downstream of it has a hole,
  // or the output is being taken this cycle.
  always_comb begin
    rdy_acc = out_ready;
    rdy     = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      rdy_acc = rdy_acc | ~vld_q[k];
      rdy[k]  = ena & rdy_acc;
    end
  end

  // Next-state: ready stages take their upstream neighbour; payload only moves with a
  // valid so a held output never changes under a bubble.
  always_comb begin
    up_v = STAGES'({vld_q, in_valid});
    up_dat[0] = res_d;
    for (int k = 1; k < STAGES; k++) up_dat[k] = dat_q[k-1];
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = rdy[k] ? up_v[k] : vld_q[k];
      dat_d[k] = (rdy[k] & up_v[k]) ? up_dat[k] : dat_q[k];
    end
  end

  // Pipeline registers; reset wins over ena and any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) dat_q[k] <= dat_d[k];
    end
  end

  assign in_ready     = rdy[0];
  assign out_valid    = vld_q[STAGES-1];
  assign {err, c, s}  = dat_q[STAGES-1];

endmodule

// File: tb/tb_add_subb_csd_pipe.sv
// Testbench for add_subb_csd_pipe (W=4, STAGES=2): directed scenarios plus an
// exhaustive digit-vector sweep, checked against an integer-arithmetic model.
module tb_add_subb_csd_pipe;
  localparam int W      = 4;
  localparam int STAGES = 2;

  logic           clk = 1'b0;
  logic           rst, ena, in_valid, in_ready, subb_a, subb_b;
  logic           out_valid, out_ready, err;
  logic [2*W-1:0] a, b, s;
  logic [1:0]     c;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  bit experr_q[$];
  int got_q[$];
  bit goterr_q[$];
  bit gotbad_q[$];

  logic           ir_s, ov_s;
  logic [2*W+2:0] out_s;

  add_subb_csd_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .subb_a(subb_a), .subb_b(subb_b), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .s(s), .err(err)
  );

  always #5 clk = ~clk;

  // value of a digit vector; 11 digits count as 0 and raise ill
  function automatic int sd_val(input logic [2*W-1:0] v, output bit ill);
    int acc;
    logic [1:0] d;
    acc = 0;
    ill = 1'b0;
    for (int i = W-1; i >= 0; i--) begin
      d = v[2*i +: 2];
      acc = acc * 2;
      if (d == 2'b01) acc = acc + 1;
      else if (d == 2'b10) acc = acc - 1;
      else if (d == 2'b11) ill = 1'b1;
    end
    return acc;
  endfunction

  function automatic logic [2*W-1:0] rand_csd();
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case ($urandom_range(0, 2))
        0:       r[2*i +: 2] = 2'b00;
        1:       r[2*i +: 2] = 2'b01;
        default: r[2*i +: 2] = 2'b10;
      endcase
    end
    return r;
  endfunction

  // base-3 index -> digit vector (0 -> 0, 1 -> +1, 2 -> -1)
  function automatic logic [2*W-1:0] idx_csd(input int n);
    logic [2*W-1:0] r;
    int m;
    r = '0;
    m = n;
    for (int i = 0; i < W; i++) begin
      case (m % 3)
        0:       r[2*i +: 2] = 2'b00;
        1:       r[2*i +: 2] = 2'b01;
        default: r[2*i +: 2] = 2'b10;
      endcase
      m = m / 3;
    end
    return r;
  endfunction

  // one clock cycle: inputs were driven at the preceding negedge; sample, log transfers
  task automatic step();
    int va, vb, cv, sv;
    bit ia, ib, bad;
    #1;
    ir_s  = in_ready;
    ov_s  = out_valid;
    out_s = {err, c, s};
    if (rst) begin
      exp_q.delete();
      experr_q.delete();
    end else begin
      if (ov_s && out_ready && ena) begin
        cv = (c == 2'b01) ? 1 : ((c == 2'b10) ? -1 : 0);
        sv = sd_val(s, bad);
        got_q.push_back(cv * (1 << W) + sv);
        goterr_q.push_back(err);
        gotbad_q.push_back(bad || (c == 2'b11));
      end
      if (in_valid && ir_s) begin
        va = sd_val(a, ia);
        vb = sd_val(b, ib);
        exp_q.push_back((subb_a ? -va : va) + (subb_b ? -vb : vb));
        experr_q.push_back(ia || ib);
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_q();
    exp_q.delete();
    experr_q.delete();
    got_q.delete();
    goterr_q.delete();
    gotbad_q.delete();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ena       = 1'b1;
    for (int n = 0; n < 20 && got_q.size() < exp_q.size(); n++) step();
    repeat (STAGES + 1) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (c !== 2'b00) begin errors++; $display("FAIL reset_c got=%b want=00", c); end
    checks++; if (s !== '0) begin errors++; $display("FAIL reset_s got=%b want=0", s); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_latency();
    int lat;
    clear_q();
    ena = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    subb_a = 1'b0; subb_b = 1'b0;
    a = 8'b00010001; b = 8'b00000101;
    step();
    checks++; if (ir_s !== 1'b1) begin errors++; $display("FAIL lat_accept in_ready got=%b want=1", ir_s); end
    in_valid = 1'b0; a = rand_csd(); b = rand_csd();
    lat = 0;
    ov_s = 1'b0;
    while (!ov_s && lat < 10) begin
      step();
      lat++;
    end
    checks++; if (lat != STAGES) begin errors++; $display("FAIL latency got=%0d want=%0d", lat, STAGES); end
    drain();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL lat_count got=%0d want=1", got_q.size()); end
    else if (got_q[0] != 8 || goterr_q[0] !== 1'b0) begin
      errors++; $display("FAIL lat_value got=%0d err=%b want=8 err=0", got_q[0], goterr_q[0]);
    end
  endtask

  task automatic test_directed();
    clear_q();
    ena = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    subb_a = 1'b1; subb_b = 1'b0; a = 8'b00010101; b = 8'b00000000;
    step();
    subb_a = 1'b1; subb_b = 1'b1; a = 8'b01010101; b = 8'b01010101;
    step();
    drain();
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL dir_count got=%0d want=2", got_q.size()); end
    else begin
      if (got_q[0] != -7 || goterr_q[0] !== 1'b0) begin
        errors++; $display("FAIL dir_neg7 got=%0d err=%b want=-7 err=0", got_q[0], goterr_q[0]);
      end
      checks++;
      if (got_q[1] != -30 || goterr_q[1] !== 1'b0 || gotbad_q[1]) begin
        errors++; $display("FAIL dir_neg30 got=%0d err=%b bad=%b want=-30 err=0", got_q[1], goterr_q[1], gotbad_q[1]);
      end
    end
  endtask

  task automatic test_err();
    clear_q();
    ena = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    subb_a = 1'b0; subb_b = 1'b0; a = 8'b00000011; b = 8'b00000100;
    step();
    a = 8'b00000001; b = 8'b00000001;
    step();
    drain();
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL err_count got=%0d want=2", got_q.size()); end
    else begin
      if (got_q[0] != 2 || goterr_q[0] !== 1'b1) begin
        errors++; $display("FAIL err_flagged got=%0d err=%b want=2 err=1", got_q[0], goterr_q[0]);
      end
      checks++;
      if (got_q[1] != 2 || goterr_q[1] !== 1'b0) begin
        errors++; $display("FAIL err_cleared got=%0d err=%b want=2 err=0", got_q[1], goterr_q[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    clear_q();
    ena = 1'b1; out_ready = 1'b1; acc = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; a = rand_csd(); b = rand_csd();
      subb_a = 1'($urandom); subb_b = 1'($urandom);
      step();
      if (ir_s) acc++;
    end
    checks++; if (acc != 16) begin errors++; $display("FAIL b2b_accepts got=%0d want=16", acc); end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i] || goterr_q[i] !== experr_q[i] || gotbad_q[i]) begin
        errors++; $display("FAIL b2b[%0d] got=%0d err=%b bad=%b want=%0d err=%b", i, got_q[i], goterr_q[i], gotbad_q[i], exp_q[i], experr_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    int acc;
    logic [2*W+2:0] snap;
    clear_q();
    ena = 1'b1; acc = 0; snap = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1; out_ready = 1'b0; a = rand_csd(); b = rand_csd();
      subb_a = 1'($urandom); subb_b = 1'($urandom);
      step();
      if (ir_s) acc++;
      if (cyc == 2) snap = out_s;
      if (cyc >= 2) begin
        checks++;
        if (ov_s !== 1'b1 || out_s !== snap) begin
          errors++; $display("FAIL stall_hold cyc=%0d got ov=%b out=%h want ov=1 out=%h", cyc, ov_s, out_s, snap);
        end
      end
    end
    checks++; if (acc != 2) begin errors++; $display("FAIL stall_accepts got=%0d want=2", acc); end
    out_ready = 1'b1; in_valid = 1'b1; a = rand_csd(); b = rand_csd();
    step();
    checks++; if (ir_s !== 1'b1) begin errors++; $display("FAIL full_passthru in_ready got=%b want=1", ir_s); end
    drain();
    checks++; if (got_q.size() != 3 || exp_q.size() != 3) begin errors++; $display("FAIL stall_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i] || goterr_q[i] !== experr_q[i] || gotbad_q[i]) begin
        errors++; $display("FAIL stall[%0d] got=%0d err=%b want=%0d err=%b", i, got_q[i], goterr_q[i], exp_q[i], experr_q[i]);
      end
    end
  endtask

  task automatic test_reset_flight();
    clear_q();
    ena = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    a = rand_csd(); b = rand_csd();
    step();
    a = rand_csd(); b = rand_csd();
    step();
    rst = 1'b1; out_ready = 1'b1; a = rand_csd();
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (ov_s !== 1'b0) begin errors++; $display("FAIL rstf_out_valid got=%b want=0", ov_s); end
    checks++; if (out_s !== '0) begin errors++; $display("FAIL rstf_outputs got=%h want=0", out_s); end
    repeat (4) step();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstf_stale got=%0d results want=0", got_q.size()); end
  endtask

  task automatic test_ena();
    logic [2*W+3:0] snap;
    clear_q();
    ena = 1'b1; out_ready = 1'b1; snap = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = rand_csd(); b = rand_csd();
      subb_a = 1'($urandom); subb_b = 1'($urandom);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      ena = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = rand_csd(); b = rand_csd();
      step();
      checks++; if (ir_s !== 1'b0) begin errors++; $display("FAIL ena_in_ready k=%0d got=%b want=0", k, ir_s); end
      if (k == 0) snap = {ov_s, out_s};
      checks++;
      if ({ov_s, out_s} !== snap || ov_s !== 1'b1) begin
        errors++; $display("FAIL ena_hold k=%0d got=%h want=%h", k, {ov_s, out_s}, snap);
      end
    end
    drain();
    checks++; if (got_q.size() != 3 || exp_q.size() != 3) begin errors++; $display("FAIL ena_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i] || goterr_q[i] !== experr_q[i] || gotbad_q[i]) begin
        errors++; $display("FAIL ena[%0d] got=%0d err=%b want=%0d err=%b", i, got_q[i], goterr_q[i], exp_q[i], experr_q[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int n, cyc;
    clear_q();
    ena = 1'b1; n = 0; cyc = 0;
    while (n < 81*81*4 && cyc < 70000) begin
      out_ready = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) != 0) begin
        in_valid = 1'b1;
        a = idx_csd(n / 324);
        b = idx_csd((n / 4) % 81);
        subb_a = ((n % 4) >= 2);
        subb_b = ((n % 2) == 1);
      end else begin
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        subb_a = 1'($urandom); subb_b = 1'($urandom);
      end
      step();
      if (in_valid && ir_s) n++;
      cyc++;
    end
    drain();
    checks++; if (n != 81*81*4) begin errors++; $display("FAIL sweep_budget accepted=%0d want=%0d", n, 81*81*4); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL sweep_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i] || goterr_q[i] !== experr_q[i] || gotbad_q[i]) begin
        errors++; $display("FAIL sweep[%0d] got=%0d err=%b bad=%b want=%0d err=%b", i, got_q[i], goterr_q[i], gotbad_q[i], exp_q[i], experr_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    subb_a = 1'b0; subb_b = 1'b0; a = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_directed();
    test_err();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_ena();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
